text_row_fetch: RTL and testbench

- Character-cell fetch stage directly upstream of the VGA timing block. Supplies that block's 16-bit pixel_row for each 16-pixel cell.
- On each fetch request, reads the character code from text RAM, then reads the glyph row from font ROM. The glyph row is selected by line_number.
- Delivers pixel_row on a fixed schedule that aligns with the VGA stage's cell boundary.
- Screen is 800x600 with 16x20 cells: 50 columns by 30 rows.

---
 rtl/text_disp_pkg.sv | 22 ++
 rtl/text_addr_gen.sv | 83 ++++++++
 rtl/text_row_fetch.sv | 112 +++++++++++
 tb/tb_text_row_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_disp_pkg.sv
// Shared geometry and types for the text-mode display path (fetch stage and VGA stage).
// Screen is 800x600 with 16x20 cells, giving 50 columns by 30 visible rows.
package text_disp_pkg;
   localparam int COLS       = 50;
   localparam int ROWS       = 30;
   localparam int GLYPH_H    = 20;
   localparam int TEXT_AW    = 11;
   localparam int FONT_AW    = 13;
   localparam int BLINK_LOG2 = 5;
   localparam int COL_W      = 6;
   localparam int ROW_W      = 5;
   localparam int LINE_W     = 5;

   typedef logic [7:0]  char_t;
   typedef logic [15:0] glyph_row_t;

   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_PREFETCH,
      REQ_INLINE
   } req_kind_e;
endpackage

// File: rtl/text_addr_gen.sv
// Row/column tracking and bounds check for text RAM fetches; yields the target address per request.
// With TEXT_ROW_FETCH_CURSOR_EN defined it also flags requests that land on the cursor cell.
module text_addr_gen
   import text_disp_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               new_data,
   input  logic               end_of_line,
   input  logic               end_of_frame,
   input  logic [LINE_W-1:0]  line_number,
   output logic               req,
   output logic               in_bounds,
   output logic [TEXT_AW-1:0] addr
`ifdef TEXT_ROW_FETCH_CURSOR_EN
   ,
   input  logic [COL_W-1:0]   cursor_col,
   input  logic [ROW_W-1:0]   cursor_row,
   output logic               cursor_hit
`endif
);
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic [ROW_W-1:0]   row_next;
   logic [TEXT_AW-1:0] row_base;
   logic [TEXT_AW-1:0] row_base_next;
   logic [ROW_W-1:0]   target_row;
   logic [COL_W-1:0]   target_col;
   logic [TEXT_AW-1:0] target_base;
   req_kind_e          kind;

   // A prefetch targets the scanline that starts after this edge, so it uses the post-update row.
   always_comb begin
      row_next      = row;
      row_base_next = row_base;
      if (end_of_frame) begin
         row_next      = '0;
         row_base_next = '0;
      end else if (end_of_line && (line_number == LINE_W'(GLYPH_H - 1))) begin
         row_next      = row + ROW_W'(1);
         row_base_next = row_base + TEXT_AW'(COLS);
      end

      kind = REQ_NONE;
      if (end_of_line)
         kind = REQ_PREFETCH;
      else if (new_data)
         kind = REQ_INLINE;

      if (kind == REQ_PREFETCH) begin
         target_row  = row_next;
         target_base = row_base_next;
         target_col  = '0;
      end else begin
         target_row  = row;
         target_base = row_base;
         target_col  = col + COL_W'(1);
      end

      req       = (kind != REQ_NONE);
      in_bounds = (target_col < COL_W'(COLS)) && (target_row < ROW_W'(ROWS));
      addr      = target_base + TEXT_AW'(target_col);
   end

`ifdef TEXT_ROW_FETCH_CURSOR_EN
   assign cursor_hit = (target_row == cursor_row) && (target_col == cursor_col);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         col      <= '0;
         row      <= '0;
         row_base <= '0;
      end else begin
         row      <= row_next;
         row_base <= row_base_next;
         if (kind == REQ_PREFETCH)
            col <= '0;
         else if (kind == REQ_INLINE)
            col <= col + COL_W'(1);
      end
   end
endmodule

// File: rtl/text_row_fetch.sv
// Character-cell fetch stage: text RAM -> font ROM -> pixel_row, 4 cycles after each request.
// Define TEXT_ROW_FETCH_CURSOR_EN to add cursor ports and a blinking block cursor on the last two scanlines.
module text_row_fetch
   import text_disp_pkg::*;
(
   input  logic               CLK_VGA,
   input  logic               reset,
   input  logic               newData,
   input  logic               end_of_line,
   input  logic               end_of_frame,
   input  logic [LINE_W-1:0]  line_number,
   output logic [TEXT_AW-1:0] text_addr,
   output logic               text_re,
   input  char_t              text_q,
   output logic [FONT_AW-1:0] font_addr,
   output logic               font_re,
   input  glyph_row_t         font_q,
   output glyph_row_t         pixel_row
`ifdef TEXT_ROW_FETCH_CURSOR_EN
   ,
   input  logic [COL_W-1:0]   cursor_col,
   input  logic [ROW_W-1:0]   cursor_row
`endif
);
   logic               req;
   logic               in_bounds;
   logic               fire;
   logic               synced;
   logic [TEXT_AW-1:0] addr;
   logic               s1_v, s1_ok, s2_v, s2_ok, s3_v, s3_ok;
   char_t              char_r;
   glyph_row_t         glyph;

`ifdef TEXT_ROW_FETCH_CURSOR_EN
   logic [BLINK_LOG2-1:0] blink_cnt;
   logic                  hit, s1_hit, s2_hit, s3_hit;
`endif

   text_addr_gen u_addr_gen (
      .clk          (CLK_VGA),
      .reset        (reset),
      .new_data     (newData),
      .end_of_line  (end_of_line),
      .end_of_frame (end_of_frame),
      .line_number  (line_number),
      .req          (req),
      .in_bounds    (in_bounds),
      .addr         (addr)
`ifdef TEXT_ROW_FETCH_CURSOR_EN
      ,
      .cursor_col   (cursor_col),
      .cursor_row   (cursor_row),
      .cursor_hit   (hit)
`endif
   );

   // The frame-boundary prefetch itself must issue, so end_of_frame counts as synced in its own cycle.
   assign fire      = !reset && req && (synced || end_of_frame);
   assign text_re   = fire && in_bounds;
   assign text_addr = text_re ? addr : '0;
   assign font_re   = s2_v && s2_ok;
   assign font_addr = font_re ? {char_r, line_number} : '0;

`ifdef TEXT_ROW_FETCH_CURSOR_EN
   assign glyph = (s3_hit && (line_number >= LINE_W'(GLYPH_H - 2)) && blink_cnt[BLINK_LOG2-1])
                  ? ~font_q : font_q;

   always_ff @(posedge CLK_VGA) begin
      if (reset) begin
         blink_cnt <= '0;
         s1_hit    <= 1'b0;
         s2_hit    <= 1'b0;
         s3_hit    <= 1'b0;
      end else begin
         if (end_of_frame)
            blink_cnt <= blink_cnt + BLINK_LOG2'(1);
         s1_hit <= hit;
         s2_hit <= s1_hit;
         s3_hit <= s2_hit;
      end
   end
`else
   assign glyph = font_q;
`endif

   always_ff @(posedge CLK_VGA) begin
      if (reset) begin
         synced    <= 1'b0;
         s1_v      <= 1'b0;
         s1_ok     <= 1'b0;
         s2_v      <= 1'b0;
         s2_ok     <= 1'b0;
         s3_v      <= 1'b0;
         s3_ok     <= 1'b0;
         char_r    <= '0;
         pixel_row <= '0;
      end else begin
         if (end_of_frame)
            synced <= 1'b1;
         s1_v  <= fire;
         s1_ok <= text_re;
         s2_v  <= s1_v;
         s2_ok <= s1_ok;
         s3_v  <= s2_v;
         s3_ok <= s2_ok;
         if (s1_v)
            char_r <= text_q;
         if (s3_v)
            pixel_row <= s3_ok ? glyph : '0;
      end
   end
endmodule

// File: tb/tb_text_row_fetch.sv
// Self-checking bench for text_row_fetch: table vectors, hand sequences and a randomized full frame.
// Cursor checks are compiled in when TEXT_ROW_FETCH_CURSOR_EN is defined.
module tb_text_row_fetch;
   localparam int K_ND  = 0;
   localparam int K_EOL = 1;
   localparam int K_EOF = 2;

   logic        CLK_VGA;
   logic        reset;
   logic        newData;
   logic        end_of_line;
   logic        end_of_frame;
   logic [4:0]  line_number;
   logic [10:0] text_addr;
   logic        text_re;
   logic [7:0]  text_q;
   logic [12:0] font_addr;
   logic        font_re;
   logic [15:0] font_q;
   logic [15:0] pixel_row;
`ifdef TEXT_ROW_FETCH_CURSOR_EN
   logic [5:0]  cursor_col;
   logic [4:0]  cursor_row;
`endif

   logic [7:0]  text_mem [0:2047];
   logic [15:0] font_mem [0:8191];

   int total = 0;
   int bad   = 0;

   // Reference model: scanline index, last fetched column, sync flag, frame count, expected pixel_row
   int          m_scan;
   int          m_col;
   logic        m_synced;
   logic [4:0]  m_frames;
   logic [15:0] m_pix;

   typedef struct {
      int          kind;
      logic        exp_re;
      logic [10:0] exp_addr;
      logic        chk_pix;
      logic [15:0] exp_pix;
   } vec_t;
   vec_t vecs [8];

   text_row_fetch dut (
      .CLK_VGA      (CLK_VGA),
      .reset        (reset),
      .newData      (newData),
      .end_of_line  (end_of_line),
      .end_of_frame (end_of_frame),
      .line_number  (line_number),
      .text_addr    (text_addr),
      .text_re      (text_re),
      .text_q       (text_q),
      .font_addr    (font_addr),
      .font_re      (font_re),
      .font_q       (font_q),
      .pixel_row    (pixel_row)
`ifdef TEXT_ROW_FETCH_CURSOR_EN
      ,
      .cursor_col   (cursor_col),
      .cursor_row   (cursor_row)
`endif
   );

   initial begin
      CLK_VGA = 1'b0;
      forever #5 CLK_VGA = ~CLK_VGA;
   end

   always @(posedge CLK_VGA) begin
      if (text_re) text_q <= text_mem[text_addr];
      if (font_re) font_q <= font_mem[font_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK_VGA);
         checkOutput("idle_hold", pixel_row, m_pix);
         @(posedge CLK_VGA); #1;
      end
   endtask

   task automatic resetDut();
      reset = 1'b1;
      newData = 1'b0; end_of_line = 1'b0; end_of_frame = 1'b0;
      @(posedge CLK_VGA); #1;
      @(negedge CLK_VGA);
      checkOutput("rst_pixel_row", pixel_row, 0);
      checkOutput("rst_text_re", text_re, 0);
      checkOutput("rst_font_re", font_re, 0);
      checkOutput("rst_text_addr", text_addr, 0);
      checkOutput("rst_font_addr", font_addr, 0);
      @(posedge CLK_VGA); #1;
      reset = 1'b0;
      m_synced = 1'b0;
      m_frames = '0;
      m_pix    = '0;
      m_col    = 0;
      m_scan   = int'(line_number);
   endtask

   // One request cycle plus the 4-cycle pipeline; returns what the DUT showed at N and N+4
   task automatic applyStimulus(input int kind, output logic re, output logic [10:0] addr,
                                output logic [15:0] pix);
      int tscan, tcol, row, line, taddr, fidx;
      logic ok, cur;
      if (kind == K_EOF) begin
         tscan = 0; tcol = 0;
         m_synced = 1'b1;
         m_frames = m_frames + 5'd1;
      end else if (kind == K_EOL) begin
         tscan = m_scan + 1; tcol = 0;
      end else begin
         tscan = m_scan; tcol = m_col + 1;
      end
      row   = tscan / 20;
      line  = tscan % 20;
      ok    = m_synced && (tcol < 50) && (row < 30);
      taddr = row * 50 + tcol;
      fidx  = ok ? int'(text_mem[taddr]) * 32 + line : 0;
      cur   = 1'b0;
`ifdef TEXT_ROW_FETCH_CURSOR_EN
      cur = (row == int'(cursor_row)) && (tcol == int'(cursor_col)) && (line >= 18) && m_frames[4];
`endif
      newData      = (kind == K_ND);
      end_of_line  = (kind != K_ND);
      end_of_frame = (kind == K_EOF);
      @(negedge CLK_VGA);
      re = text_re; addr = text_addr;
      checkOutput("text_re", text_re, ok);
      if (ok) checkOutput("text_addr", text_addr, taddr);
      @(posedge CLK_VGA); #1;
      newData = 1'b0; end_of_line = 1'b0; end_of_frame = 1'b0;
      if (kind != K_ND) begin
         m_scan = tscan;
         line_number = 5'(line);
      end
      m_col = tcol;
      @(negedge CLK_VGA);
      @(negedge CLK_VGA);
      checkOutput("font_re", font_re, ok);
      if (ok) checkOutput("font_addr", font_addr, fidx);
      @(negedge CLK_VGA);
      checkOutput("pix_before_n4", pixel_row, m_pix);
      if (m_synced) m_pix = ok ? (font_mem[fidx] ^ (cur ? 16'hFFFF : 16'h0000)) : 16'h0000;
      @(negedge CLK_VGA);
      checkOutput("pix_at_n4", pixel_row, m_pix);
      pix = pixel_row;
      @(posedge CLK_VGA); #1;
   endtask

   initial begin
      logic        re;
      logic [10:0] addr;
      logic [15:0] pix;
      logic [15:0] expg;
      int          nreq;

      for (int i = 0; i < 2048; i++) text_mem[i] = 8'($urandom);
      for (int i = 0; i < 8192; i++) font_mem[i] = 16'($urandom);
      text_mem[0] = 8'h41;
      font_mem[13'h41 << 5] = 16'hF00F;
      text_q = '0; font_q = '0;
      reset = 1'b1; newData = 1'b0; end_of_line = 1'b0; end_of_frame = 1'b0;
      line_number = '0;
`ifdef TEXT_ROW_FETCH_CURSOR_EN
      cursor_col = 6'd3;
      cursor_row = 5'd1;
`endif
      m_scan = 0; m_col = 0; m_synced = 1'b0; m_frames = '0; m_pix = '0;
      @(posedge CLK_VGA); #1;
      resetDut();

      vecs[0] = '{K_ND,  1'b0, 11'd0, 1'b0, 16'h0000};
      vecs[1] = '{K_EOL, 1'b0, 11'd0, 1'b0, 16'h0000};
      vecs[2] = '{K_EOF, 1'b1, 11'd0, 1'b1, 16'hF00F};
      vecs[3] = '{K_ND,  1'b1, 11'd1, 1'b0, 16'h0000};
      vecs[4] = '{K_ND,  1'b1, 11'd2, 1'b0, 16'h0000};
      vecs[5] = '{K_EOL, 1'b1, 11'd0, 1'b0, 16'h0000};
      vecs[6] = '{K_ND,  1'b1, 11'd1, 1'b0, 16'h0000};
      vecs[7] = '{K_EOF, 1'b1, 11'd0, 1'b1, 16'hF00F};
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].kind, re, addr, pix);
         checkOutput("vec_re", re, vecs[i].exp_re);
         if (vecs[i].exp_re) checkOutput("vec_addr", addr, vecs[i].exp_addr);
         if (vecs[i].chk_pix) checkOutput("vec_pix", pix, vecs[i].exp_pix);
      end

      // Mid-frame reset: blank and silent until the next frame boundary
      for (int i = 0; i < 3; i++) applyStimulus(K_EOL, re, addr, pix);
      resetDut();
      applyStimulus(K_ND, re, addr, pix);
      checkOutput("unsynced_re_nd", re, 0);
      applyStimulus(K_EOL, re, addr, pix);
      checkOutput("unsynced_re_eol", re, 0);
      checkOutput("unsynced_pix", pix, 0);
      applyStimulus(K_EOF, re, addr, pix);
      checkOutput("resync_re", re, 1);
      checkOutput("resync_addr", addr, 0);

      // Walk down to row 2 and fetch column 1 there
      for (int i = 1; i <= 40; i++) begin
         applyStimulus(K_EOL, re, addr, pix);
         if (i == 20) checkOutput("row1_base", addr, 50);
         if (i == 40) checkOutput("row2_base", addr, 100);
      end
      applyStimulus(K_ND, re, addr, pix);
      checkOutput("row2_col1_addr", addr, 101);
      expg = font_mem[int'(text_mem[101]) * 32];
      checkOutput("row2_col1_pix", pix, expg);
      idle(16);

      // Column 50 is past the right edge
      for (int c = 2; c <= 50; c++) begin
         applyStimulus(K_ND, re, addr, pix);
         if (c == 50) begin
            checkOutput("col50_re", re, 0);
            checkOutput("col50_pix", pix, 0);
         end
      end

      // Full random frame, including the vertical blanking rows
      applyStimulus(K_EOF, re, addr, pix);
      for (int s = 0; s < 627; s++) begin
         nreq = $urandom_range(0, 2);
         for (int k = 0; k < nreq; k++) begin
            applyStimulus(K_ND, re, addr, pix);
            idle($urandom_range(0, 3));
         end
         applyStimulus(K_EOL, re, addr, pix);
         if (s == 599) checkOutput("row30_prefetch_re", re, 0);
      end

`ifdef TEXT_ROW_FETCH_CURSOR_EN
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 32 && (m_frames[4] != (pass == 0)); i++)
            applyStimulus(K_EOF, re, addr, pix);
         if (m_frames[4] != (pass == 0)) applyStimulus(K_EOF, re, addr, pix);
         for (int i = 0; i < 38; i++) applyStimulus(K_EOL, re, addr, pix);
         for (int i = 0; i < 3; i++) applyStimulus(K_ND, re, addr, pix);
         expg = font_mem[int'(text_mem[53]) * 32 + 18];
         if (pass == 0) checkOutput("cursor_on_pix", pix, ~expg);
         else checkOutput("cursor_off_pix", pix, expg);
      end
`endif

      applyStimulus(K_EOF, re, addr, pix);
      checkOutput("final_eof_addr", addr, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
